// File: rtl/uart_rx.sv
// UART 8N1 receiver with 16x oversampling, framing-error detection and
// break handling. All decisions are taken on the synchronized line.
module uart_rx #(
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned MID_SAMPLE  = 7,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_clk_rx,
   input  logic       i_rxd,
   output logic [7:0] o_rx_data,
   output logic       o_rx_done,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_SAMPLE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   logic [CNT_W-1:0]       cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shift_q;

   assign rxd_s = sync_q[SYNC_STAGES-1];

   // Metastability synchronizer for the asynchronous line; resets to idle-high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_rxd};
      end
   end

   // Receive FSM: start validation, mid-bit data sampling, stop check, break wait.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift_q     <= '0;
         o_rx_data   <= '0;
         o_rx_done   <= 1'b0;
         o_frame_err <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         o_rx_done   <= 1'b0;
         o_frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rxd_s) begin
                  state  <= START;
                  o_busy <= 1'b1;
               end
            end
            START: begin
               if (i_clk_rx) begin
                  if (cnt == CNT_MID) begin
                     cnt <= '0;
                     if (!rxd_s) begin
                        bit_idx <= '0;
                        state   <= DATA;
                     end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            DATA: begin
               if (i_clk_rx) begin
                  if (cnt == CNT_LAST) begin
                     cnt     <= '0;
                     shift_q <= {rxd_s, shift_q[7:1]};
                     if (bit_idx == 3'd7) begin
                        state <= STOP;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            STOP: begin
               if (i_clk_rx) begin
                  if (cnt == CNT_LAST) begin
                     cnt <= '0;
                     if (rxd_s) begin
                        o_rx_data <= shift_q;
                        o_rx_done <= 1'b1;
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                     end else begin
                        o_frame_err <= 1'b1;
                        state       <= BRK;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            BRK: begin
               // A held-low line must not be mistaken for a new start bit.
               if (rxd_s) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// checked every cycle against an event-queue model of received bytes.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       i_clk_rx = 1'b0;
   logic       i_rxd = 1'b1;
   logic [7:0] o_rx_data;
   logic       o_rx_done;
   logic       o_frame_err;
   logic       o_busy;

   uart_rx dut (
      .clk        (clk),
      .reset      (reset),
      .i_clk_rx   (i_clk_rx),
      .i_rxd      (i_rxd),
      .o_rx_data  (o_rx_data),
      .o_rx_done  (o_rx_done),
      .o_frame_err(o_frame_err),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         err;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        ev;
   int         n_chk = 0;
   int         n_pass = 0;
   int         n_done = 0;
   int         n_err = 0;
   int         tick_div = 1;
   int         cyc = 0;
   int         start_cyc = 0;
   int         done_cyc = 0;
   logic [7:0] last_good = 8'h00;
   bit         prev_done = 1'b0;
   bit         prev_err = 1'b0;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   always @(posedge clk) cyc++;

   // Tick enable: one pulse every tick_div clocks (constant high when tick_div==1).
   initial begin
      int c;
      c = 0;
      forever begin
         @(posedge clk);
         #1;
         if (c >= tick_div - 1) begin
            c = 0;
            i_clk_rx = 1'b1;
         end else begin
            c++;
            i_clk_rx = 1'b0;
         end
      end
   end

   // Compare process: outputs against the expected-event queue on every cycle.
   always @(negedge clk) begin
      if (!reset) begin
         chk(o_rx_data == 8'h00, "rst_data", 32'(o_rx_data), 0);
         chk(!o_rx_done && !o_frame_err && !o_busy, "rst_flags",
             32'({o_rx_done, o_frame_err, o_busy}), 0);
         last_good = 8'h00;
         prev_done = 1'b0;
         prev_err  = 1'b0;
      end else begin
         if (o_rx_done && o_frame_err)
            chk(1'b0, "done_and_err", 3, 0);
         if (o_rx_done) begin
            n_done++;
            done_cyc = cyc;
            chk(!prev_done, "done_width", 2, 1);
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_done", 32'(o_rx_data), 0);
            end else begin
               ev = exp_q.pop_front();
               chk(!ev.err, "done_kind", 1, 32'(ev.err));
               chk(o_rx_data == ev.data, "rx_data", 32'(o_rx_data), 32'(ev.data));
               last_good = ev.data;
            end
         end else if (o_frame_err) begin
            n_err++;
            chk(!prev_err, "err_width", 2, 1);
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_err", 1, 0);
            end else begin
               ev = exp_q.pop_front();
               chk(ev.err, "err_kind", 1, 32'(ev.err));
            end
            chk(o_rx_data == last_good, "data_hold_err", 32'(o_rx_data), 32'(last_good));
         end else begin
            chk(o_rx_data == last_good, "data_hold", 32'(o_rx_data), 32'(last_good));
         end
         prev_done = o_rx_done;
         prev_err  = o_frame_err;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives frame bits lo..hi of {stop, data, start}, each one bit period long.
   task automatic send_range(input logic [7:0] b, input bit stop, input int lo, input int hi);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = lo; i <= hi; i++) begin
         i_rxd = f[i];
         if (i == 0) start_cyc = cyc;
         wait_clk(16 * tick_div);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop);
      exp_q.push_back('{err: !stop, data: b});
      send_range(b, stop, 0, 9);
   endtask

   task automatic idle_bits(input int n);
      i_rxd = 1'b1;
      wait_clk(n * 16 * tick_div);
   endtask

   initial begin
      logic [7:0] b;
      bit         bad;
      bit         bad_prev;
      int         r;

      wait_clk(4);
      reset = 1'b1;
      wait_clk(2);
      chk(o_busy == 1'b0, "busy_after_reset", 32'(o_busy), 0);
      chk(o_rx_data == 8'h00, "data_after_reset", 32'(o_rx_data), 0);

      // 0xA5 at 16 ticks per bit, tick every 2 clk
      tick_div = 2;
      idle_bits(1);
      exp_q.push_back('{err: 1'b0, data: 8'hA5});
      send_range(8'hA5, 1'b1, 0, 4);
      chk(o_busy == 1'b1, "busy_mid_frame", 32'(o_busy), 1);
      send_range(8'hA5, 1'b1, 5, 9);
      idle_bits(1);
      chk(o_rx_data == 8'hA5, "a5_data", 32'(o_rx_data), 32'hA5);
      chk(n_done == 1, "a5_done_count", n_done, 1);
      chk(n_err == 0, "a5_err_count", n_err, 0);
      chk(o_busy == 1'b0, "a5_busy_after", 32'(o_busy), 0);

      // Start glitch: low for 4 ticks
      i_rxd = 1'b0;
      wait_clk(4 * tick_div);
      idle_bits(1);
      chk(o_busy == 1'b0, "glitch_idle", 32'(o_busy), 0);
      chk(n_done == 1 && n_err == 0, "glitch_no_strobe", n_done + n_err, 1);
      chk(o_rx_data == 8'hA5, "glitch_data", 32'(o_rx_data), 32'hA5);

      // 0x3C with bad stop, line held low 3 more bits, then 0x81
      send_frame(8'h3C, 1'b0);
      wait_clk(3 * 16 * tick_div);
      chk(n_err == 1, "break_err_count", n_err, 1);
      chk(n_done == 1, "break_no_start", n_done, 1);
      chk(o_rx_data == 8'hA5, "break_data_hold", 32'(o_rx_data), 32'hA5);
      idle_bits(1);
      send_frame(8'h81, 1'b1);
      idle_bits(1);
      chk(o_rx_data == 8'h81, "after_break_data", 32'(o_rx_data), 32'h81);
      chk(n_done == 2 && n_err == 1, "after_break_counts", n_done * 16 + n_err, 33);

      // Back-to-back 0x00 then 0xFF
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle_bits(1);
      chk(o_rx_data == 8'hFF, "b2b_data", 32'(o_rx_data), 32'hFF);
      chk(n_done == 4, "b2b_done_count", n_done, 4);

      // Reset in the middle of D4 of 0x55, then 0x96
      send_range(8'h55, 1'b1, 0, 4);
      i_rxd = 1'b1;
      wait_clk(8 * tick_div);
      reset = 1'b0;
      i_rxd = 1'b1;
      wait_clk(3);
      chk(o_rx_data == 8'h00, "mid_reset_data", 32'(o_rx_data), 0);
      chk(o_busy == 1'b0, "mid_reset_busy", 32'(o_busy), 0);
      reset = 1'b1;
      idle_bits(1);
      send_frame(8'h96, 1'b1);
      idle_bits(1);
      chk(o_rx_data == 8'h96, "post_reset_data", 32'(o_rx_data), 32'h96);
      chk(n_done == 5, "post_reset_done_count", n_done, 5);

      // Tick on every clk: 0x7E, fixed latency from start edge
      tick_div = 1;
      idle_bits(1);
      send_frame(8'h7E, 1'b1);
      idle_bits(1);
      chk(o_rx_data == 8'h7E, "fast_tick_data", 32'(o_rx_data), 32'h7E);
      chk(done_cyc - start_cyc == 155, "fast_tick_latency", done_cyc - start_cyc, 155);

      // Randomized frames, tick rates, glitches, breaks and back-to-back runs
      bad_prev = 1'b1;
      for (int n = 0; n < 24; n++) begin
         if (bad_prev || $urandom_range(0, 2) != 0) begin
            tick_div = $urandom_range(1, 3);
            idle_bits($urandom_range(1, 2));
            if ($urandom_range(0, 4) == 0) begin
               i_rxd = 1'b0;
               wait_clk($urandom_range(1, 5) * tick_div);
               idle_bits(1);
            end
         end
         b   = 8'($urandom);
         bad = ($urandom_range(0, 4) == 0);
         send_frame(b, !bad);
         if (bad) begin
            r = $urandom_range(0, 2);
            wait_clk(1 + r * 16 * tick_div);
            i_rxd = 1'b1;
         end
         bad_prev = bad;
      end
      idle_bits(2);

      // Bounded drain of outstanding expected events
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_clk(1);
      chk(exp_q.size() == 0, "all_events_seen", exp_q.size(), 0);
      chk(o_busy == 1'b0, "busy_end", 32'(o_busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver paired with the existing transmitter. Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the serial line. Samples with a 16x-oversampling tick enable generated by the shared baud generator. Presents the received byte with a one-clk done strobe and flags framing errors. Sits between the board RX pin and the CPU I/O register that consumes bytes.

Parameters:
OVERSAMPLE, 16, tick-enable pulses per bit period; the counter is $clog2(OVERSAMPLE) bits wide.
MID_SAMPLE, 7, counter value at which the start bit is re-checked (OVERSAMPLE/2-1).
SYNC_STAGES, 2, flip-flop depth of the i_rxd metastability synchronizer (minimum 2).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous active-low reset.
i_clk_rx  input  1  16x-baud tick enable; one clk wide; frequency OVERSAMPLE*baud.
i_rxd  input  1  asynchronous serial line; idles high.
o_rx_data  output  8  last correctly received byte; holds until the next good frame.
o_rx_done  output  1  one-clk pulse when o_rx_data has been updated.
o_frame_err  output  1  one-clk pulse when the stop bit is sampled low.
o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, reset=0): all synchronizer stages=1; state=IDLE; sample counter=0; bit index=0; shift register=0; o_rx_data=8'h00; o_rx_done=0; o_frame_err=0; o_busy=0.
- All decisions use the synchronized line rxd_s (SYNC_STAGES clk of latency). Counter and sampling advance only on cycles with i_clk_rx=1.
- IDLE: counter held at 0. rxd_s==0 on any clk -> START.
- START: counter increments on each tick. At the tick where counter==MID_SAMPLE:
  - rxd_s==0 -> counter:=0, bit index:=0, go to DATA.
  - rxd_s==1 -> glitch; go to IDLE with no outputs.
- DATA: counter increments on each tick. At the tick where counter==OVERSAMPLE-1 (mid-bit):
  - shift rxd_s into the MSB of the shift register (right shift, so LSB arrives first); counter:=0.
  - if bit index==7 -> go to STOP; else bit index+1.
- STOP: at the tick where counter==OVERSAMPLE-1:
  - rxd_s==1 -> o_rx_data:=shift register; o_rx_done=1 on the next clk for exactly one cycle; go to IDLE.
  - rxd_s==0 -> o_rx_data unchanged; o_frame_err=1 on the next clk for exactly one cycle; go to BREAK.
- BREAK: wait for rxd_s==1, then go to IDLE. A held-low line (break) therefore produces exactly one o_frame_err and never a spurious start.
- o_rx_done and o_frame_err are registered and mutually exclusive. They never last longer than one clk, regardless of tick rate.
- Latency: o_rx_done rises 1 clk after the stop-bit mid-sample tick. This is about 9.5 bit times plus SYNC_STAGES+1 clk after the falling start edge.
- Back-to-back frames: return to IDLE happens at the stop-bit middle. A start edge arriving half a bit later must be caught with no lost frame.
- Tick cadence: no tick for many clk -> state and counter hold. A tick on every clk is legal.
- Reset mid-frame: everything returns to its reset value immediately. A partial byte is discarded with no strobe.
- i_rxd changing between ticks affects only the START detection in IDLE. All data sampling happens on ticks.

Test Plan:
- 0xA5 frame (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 16 ticks/bit -> o_rx_data=8'hA5, one o_rx_done pulse, o_frame_err=0, o_busy low afterwards.
- Line low for 4 ticks then high -> state back to IDLE, no o_rx_done, no o_frame_err, o_rx_data unchanged.
- Frame 0x3C with stop bit driven 0, line held low 3 bit times, then 0x81 sent -> one o_frame_err pulse, o_rx_data stays at the prior value, no start detected during the low period, then o_rx_data=8'h81 with o_rx_done.
- Back-to-back 0x00 then 0xFF with no idle gap -> two o_rx_done pulses with o_rx_data 8'h00 then 8'hFF.
- Assert reset during bit D4 of 0x55, release it, then send 0x96 -> no strobe for the aborted frame, o_rx_data=8'h00 after reset, then o_rx_data=8'h96.
- i_clk_rx tied high (tick every clk) with 0x7E -> o_rx_data=8'h7E and o_rx_done exactly one clk wide.
